cw305_reg_nn_core: RTL

- Parametrised successor of the CW305 ML register block. Holds NN inputs, weights and biases written byte-wise over the USB register interface.
- Computes one dense layer, out[o] = sat(relu(bias[o] + sum_i w[o][i]*x[i])), with a sequential one-MAC-per-cycle engine.
- Exposes results, status and a run cycle count for readback, and drives a scope trigger while computing.
- Sits between cw305_usb_reg_fe and the top level, all on usb_clk.

---
 rtl/cw305_reg_nn_core_pkg.sv | 47 ++++
 rtl/ml_mac_sat.sv | 49 ++++
 rtl/cw305_reg_nn_core.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cw305_reg_nn_core_pkg.sv
// ----------------------------------------------------------------------------
// cw305_reg_nn_core_pkg
// Shared definitions for the CW305 dense-layer register block:
//   - USB register addresses of the NN register map
//   - bit positions inside the CTRL and STATUS bytes
//   - engine FSM state encoding
//   - helper that packs the STATUS byte
// ----------------------------------------------------------------------------
package cw305_reg_nn_core_pkg;

    // Register addresses (compared against the zero-extended reg_address)
    localparam int REG_NN_INPUTS  = 32'd0;
    localparam int REG_NN_WEIGHTS = 32'd1;
    localparam int REG_NN_BIAS    = 32'd2;
    localparam int REG_NN_RES     = 32'd3;
    localparam int REG_NN_CTRL    = 32'd4;
    localparam int REG_NN_STATUS  = 32'd5;
    localparam int REG_NN_CYCLES  = 32'd6;

    // CTRL byte bits
    localparam int CTRL_GO_BIT      = 32'd0;
    localparam int CTRL_RELU_BIT    = 32'd1;

    // STATUS byte bits
    localparam int STATUS_BUSY_BIT  = 32'd0;
    localparam int STATUS_DONE_BIT  = 32'd1;
    localparam int STATUS_WRERR_BIT = 32'd2;

    // Engine states
    typedef enum logic [1:0] {
        NN_IDLE  = 2'd0,
        NN_MAC   = 2'd1,
        NN_STORE = 2'd2
    } nn_state_e;

    // Pack the read-only STATUS byte
    function automatic logic [7:0] status_byte(input logic busy, input logic done,
                                               input logic wr_err);
        logic [7:0] s;
        s = 8'h00;
        s[STATUS_BUSY_BIT]  = busy;
        s[STATUS_DONE_BIT]  = done;
        s[STATUS_WRERR_BIT] = wr_err;
        return s;
    endfunction

endpackage

// File: rtl/ml_mac_sat.sv
// ----------------------------------------------------------------------------
// ml_mac_sat
// Combinational datapath of the dense-layer engine.
//   acc_i      : running signed accumulator
//   w_i, x_i   : signed weight and input element
//   relu_en_i  : clamp negative accumulator to zero before saturation
//   sum_o      : acc_i + w_i*x_i (full width, cannot overflow)
//   sat_o      : relu/saturate of acc_i to the element range
// ----------------------------------------------------------------------------
module ml_mac_sat #(
    parameter int pDATA_WIDTH = 8,
    parameter int pACC_WIDTH  = 19
) (
    input  logic signed [pACC_WIDTH-1:0]  acc_i,
    input  logic signed [pDATA_WIDTH-1:0] w_i,
    input  logic signed [pDATA_WIDTH-1:0] x_i,
    input  logic                          relu_en_i,
    output logic signed [pACC_WIDTH-1:0]  sum_o,
    output logic signed [pDATA_WIDTH-1:0] sat_o
);

    // Element range bounds expressed at accumulator width
    localparam logic signed [pACC_WIDTH-1:0] SAT_MAX =
        {{(pACC_WIDTH-pDATA_WIDTH+1){1'b0}}, {(pDATA_WIDTH-1){1'b1}}};
    localparam logic signed [pACC_WIDTH-1:0] SAT_MIN =
        {{(pACC_WIDTH-pDATA_WIDTH+1){1'b1}}, {(pDATA_WIDTH-1){1'b0}}};

    logic signed [2*pDATA_WIDTH-1:0] prod_s;
    logic signed [pACC_WIDTH-1:0]    relu_s;

    // Signed multiply-accumulate
    always_comb begin
        prod_s = w_i * x_i;
        sum_o  = acc_i + {{(pACC_WIDTH-2*pDATA_WIDTH){prod_s[2*pDATA_WIDTH-1]}}, prod_s};
    end

    // ReLU first, then clamp into the signed element range
    always_comb begin
        relu_s = (relu_en_i && acc_i[pACC_WIDTH-1]) ? {pACC_WIDTH{1'b0}} : acc_i;
        if (relu_s > SAT_MAX) begin
            sat_o = SAT_MAX[pDATA_WIDTH-1:0];
        end else if (relu_s < SAT_MIN) begin
            sat_o = SAT_MIN[pDATA_WIDTH-1:0];
        end else begin
            sat_o = relu_s[pDATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/cw305_reg_nn_core.sv
// ----------------------------------------------------------------------------
// cw305_reg_nn_core
// USB-register-mapped single dense layer: out[o] = sat(relu(bias[o] + sum w*x)),
// one MAC per usb_clk cycle.
//   usb_clk, resetn          : clock, synchronous active-low reset
//   reg_address/reg_bytecnt  : register select and byte offset
//   reg_addrvalid/reg_read/reg_write, write_data : USB register strobes
//   read_data                : registered read byte (1-cycle latency)
//   nn_trigger               : scope trigger, high while the engine runs
// ----------------------------------------------------------------------------
module cw305_reg_nn_core
    import cw305_reg_nn_core_pkg::*;
#(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pDATA_WIDTH   = 8,
    parameter int pN_IN         = 4,
    parameter int pN_OUT        = 4
) (
    input  logic                                 usb_clk,
    input  logic                                 resetn,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           read_data,
    input  logic [7:0]                           write_data,
    input  logic                                 reg_read,
    input  logic                                 reg_write,
    input  logic                                 reg_addrvalid,
    output logic                                 nn_trigger
);

    localparam int BPE      = pDATA_WIDTH / 8;
    localparam int IN_BYTES = pN_IN * BPE;
    localparam int W_BYTES  = pN_OUT * pN_IN * BPE;
    localparam int B_BYTES  = pN_OUT * BPE;
    localparam int AW       = 2*pDATA_WIDTH + $clog2(pN_IN) + 1;
    localparam int OW       = (pN_OUT > 1) ? $clog2(pN_OUT) : 1;
    localparam int IW       = (pN_IN  > 1) ? $clog2(pN_IN)  : 1;

    // Arrays kept as packed byte vectors: element k occupies bits [k*W +: W],
    // which is exactly the little-endian byte order of the register map.
    logic [IN_BYTES*8-1:0] in_q;
    logic [W_BYTES*8-1:0]  w_q;
    logic [B_BYTES*8-1:0]  b_q;
    logic [B_BYTES*8-1:0]  res_q;

    nn_state_e                   state_q, state_d;
    logic [OW-1:0]               o_q, o_d, bsel_s;
    logic [IW-1:0]               i_q, i_d;
    logic signed [AW-1:0]        acc_q, acc_d, sum_s;
    logic [31:0]                 cyc_q, cyc_d;
    logic                        done_q, done_d, err_q, err_d, relu_q, relu_d, trig_q;
    logic [7:0]                  rd_q, rd_s;
    logic [31:0]                 addr_s, bc_s;
    logic                        wr_s, go_req_s, prot_s, ctrl_wr_s;
    logic                        start_s, mac_s, store_s, busy_s, last_i_s, last_o_s;
    logic signed [pDATA_WIDTH-1:0] x_s, w_s, bias_s, sat_s;

    assign addr_s    = 32'(reg_address);
    assign bc_s      = 32'(reg_bytecnt);
    assign wr_s      = reg_addrvalid && reg_write;
    assign ctrl_wr_s = wr_s && (addr_s == REG_NN_CTRL) && (bc_s == 32'd0);
    assign go_req_s  = ctrl_wr_s && write_data[CTRL_GO_BIT];
    assign prot_s    = (addr_s == REG_NN_INPUTS) || (addr_s == REG_NN_WEIGHTS) ||
                       (addr_s == REG_NN_BIAS)   || (addr_s == REG_NN_CTRL);
    assign last_i_s  = (i_q == IW'(pN_IN - 1));
    assign last_o_s  = (o_q == OW'(pN_OUT - 1));
    assign read_data  = rd_q;
    assign nn_trigger = trig_q;

    // FSM state register
    always_ff @(posedge usb_clk) begin
        if (!resetn) state_q <= NN_IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            NN_IDLE:  state_d = go_req_s ? NN_MAC : NN_IDLE;
            NN_MAC:   state_d = last_i_s ? NN_STORE : NN_MAC;
            NN_STORE: state_d = last_o_s ? NN_IDLE : NN_MAC;
            default:  state_d = NN_IDLE;
        endcase
    end

    // FSM outputs: datapath strobes
    always_comb begin
        start_s = 1'b0;
        mac_s   = 1'b0;
        store_s = 1'b0;
        busy_s  = 1'b1;
        case (state_q)
            NN_IDLE:  begin busy_s = 1'b0; start_s = go_req_s; end
            NN_MAC:   mac_s   = 1'b1;
            NN_STORE: store_s = 1'b1;
            default:  busy_s  = 1'b0;
        endcase
    end

    // Operand selection; the bias fetched is neuron 0 on start, else the next neuron
    always_comb begin
        x_s    = '0;
        w_s    = '0;
        bias_s = '0;
        bsel_s = start_s ? {OW{1'b0}} : o_q + OW'(1);
        for (int i = 0; i < pN_IN; i++) begin
            x_s = (i_q == IW'(i)) ? in_q[i*pDATA_WIDTH +: pDATA_WIDTH] : x_s;
        end
        for (int o = 0; o < pN_OUT; o++) begin
            bias_s = (bsel_s == OW'(o)) ? b_q[o*pDATA_WIDTH +: pDATA_WIDTH] : bias_s;
            for (int i = 0; i < pN_IN; i++) begin
                w_s = (o_q == OW'(o) && i_q == IW'(i)) ?
                      w_q[(o*pN_IN+i)*pDATA_WIDTH +: pDATA_WIDTH] : w_s;
            end
        end
    end

    ml_mac_sat #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pACC_WIDTH  (AW)
    ) u_mac_sat (
        .acc_i     (acc_q),
        .w_i       (w_s),
        .x_i       (x_s),
        .relu_en_i (relu_q),
        .sum_o     (sum_s),
        .sat_o     (sat_s)
    );

    // Engine counters, accumulator, CTRL and sticky STATUS next-state
    always_comb begin
        o_d    = o_q;
        i_d    = i_q;
        acc_d  = acc_q;
        cyc_d  = cyc_q;
        done_d = done_q;
        err_d  = err_q;
        relu_d = relu_q;
        if (start_s) begin
            o_d    = '0;
            i_d    = '0;
            acc_d  = {{(AW-pDATA_WIDTH){bias_s[pDATA_WIDTH-1]}}, bias_s};
            cyc_d  = 32'd0;
            done_d = 1'b0;
            err_d  = 1'b0;
        end else if (mac_s) begin
            acc_d = sum_s;
            cyc_d = cyc_q + 32'd1;
            i_d   = last_i_s ? i_q : i_q + IW'(1);
        end else if (store_s) begin
            cyc_d = cyc_q + 32'd1;
            if (last_o_s) begin
                done_d = 1'b1;
            end else begin
                o_d   = o_q + OW'(1);
                i_d   = '0;
                acc_d = {{(AW-pDATA_WIDTH){bias_s[pDATA_WIDTH-1]}}, bias_s};
            end
        end else begin
            cyc_d = cyc_q;
        end
        // Writes to the parameter/CTRL space during a run are dropped but flagged
        err_d  = err_d | (wr_s && busy_s && prot_s);
        relu_d = (ctrl_wr_s && !busy_s) ? write_data[CTRL_RELU_BIT] : relu_d;
    end

    // Engine and control registers
    always_ff @(posedge usb_clk) begin
        if (!resetn) begin
            o_q    <= '0;
            i_q    <= '0;
            acc_q  <= '0;
            cyc_q  <= 32'd0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            relu_q <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            o_q    <= o_d;
            i_q    <= i_d;
            acc_q  <= acc_d;
            cyc_q  <= cyc_d;
            done_q <= done_d;
            err_q  <= err_d;
            relu_q <= relu_d;
            trig_q <= (state_d != NN_IDLE);
        end
    end

    // Parameter arrays (USB writes while idle) and per-neuron results
    always_ff @(posedge usb_clk) begin
        if (!resetn) begin
            in_q  <= '0;
            w_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            if (wr_s && !busy_s) begin
                for (int b = 0; b < IN_BYTES; b++) begin
                    if (addr_s == REG_NN_INPUTS && bc_s == 32'(b)) in_q[b*8 +: 8] <= write_data;
                end
                for (int b = 0; b < W_BYTES; b++) begin
                    if (addr_s == REG_NN_WEIGHTS && bc_s == 32'(b)) w_q[b*8 +: 8] <= write_data;
                end
                for (int b = 0; b < B_BYTES; b++) begin
                    if (addr_s == REG_NN_BIAS && bc_s == 32'(b)) b_q[b*8 +: 8] <= write_data;
                end
            end
            if (store_s) begin
                for (int o = 0; o < pN_OUT; o++) begin
                    if (o_q == OW'(o)) res_q[o*pDATA_WIDTH +: pDATA_WIDTH] <= sat_s;
                end
            end
        end
    end

    // Read byte mux; out-of-range bytes and unmapped addresses give 0
    always_comb begin
        rd_s = 8'h00;
        case (addr_s)
            REG_NN_INPUTS:
                for (int b = 0; b < IN_BYTES; b++) rd_s = (bc_s == 32'(b)) ? in_q[b*8 +: 8] : rd_s;
            REG_NN_WEIGHTS:
                for (int b = 0; b < W_BYTES; b++) rd_s = (bc_s == 32'(b)) ? w_q[b*8 +: 8] : rd_s;
            REG_NN_BIAS:
                for (int b = 0; b < B_BYTES; b++) rd_s = (bc_s == 32'(b)) ? b_q[b*8 +: 8] : rd_s;
            REG_NN_RES:
                for (int b = 0; b < B_BYTES; b++) rd_s = (bc_s == 32'(b)) ? res_q[b*8 +: 8] : rd_s;
            REG_NN_CTRL:
                rd_s = (bc_s == 32'd0) ? {6'd0, relu_q, 1'b0} : 8'h00;
            REG_NN_STATUS:
                rd_s = (bc_s == 32'd0) ? status_byte(busy_s, done_q, err_q) : 8'h00;
            REG_NN_CYCLES:
                for (int b = 0; b < 4; b++) rd_s = (bc_s == 32'(b)) ? cyc_q[b*8 +: 8] : rd_s;
            default:
                rd_s = 8'h00;
        endcase
    end

    // Registered read data, zero when no read strobe
    always_ff @(posedge usb_clk) begin
        if (!resetn)                        rd_q <= 8'h00;
        else if (reg_addrvalid && reg_read) rd_q <= rd_s;
        else                                rd_q <= 8'h00;
    end

endmodule
